// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier for MULT/MULTU; WIDTH iterations per product.
// Shares the start/busy/done handshake of the iterative divider. Signed operands are run as magnitudes and the sign is applied at the end.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [WIDTH:0]     acc_q;
  logic [WIDTH-1:0]   mq_q, mcand_q;
  logic               neg_q;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic [WIDTH-1:0]   mag_a_d, mag_b_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH:0]   shift_d;
  logic [2*WIDTH-1:0] prod_d, res_d;

  // 0x80..0 negates to itself, which read unsigned is the correct magnitude.
  assign mag_a_d = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign mag_b_d = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;

  assign sum_d   = acc_q + (mq_q[0] ? {1'b0, mcand_q} : '0);
  assign shift_d = {sum_d, mq_q} >> 1;
  assign prod_d  = shift_d[2*WIDTH-1:0];
  assign res_d   = neg_q ? -prod_d : prod_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else if (start) begin
      state_q <= RUN;
      mcand_q <= mag_a_d;
      mq_q    <= mag_b_d;
      neg_q   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      acc_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == RUN) begin
        acc_q   <= shift_d[2*WIDTH:WIDTH];
        mq_q    <= shift_d[WIDTH-1:0];
        count_q <= count_q + 1'b1;
        // Final shift and result write share this edge.
        if (count_q == LAST) begin
          state_q      <= IDLE;
          {hi_q, lo_q} <= res_d;
          done_q       <= 1'b1;
        end
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
endmodule
